// File: rtl/dmem_ctrl.sv
// -----------------------------------------------------------------------------
// dmem_ctrl
//   Wait-stated data-memory controller for a small word-organised RAM
//   (2**ADDR_W x 32-bit words). It accepts byte, halfword and word loads and
//   stores on little-endian byte addresses. Every access takes WAIT extra
//   cycles and completes with a one-cycle ready pulse. A misaligned access
//   completes at once with misalign raised and has no other effect.
//   The whole array is cleared by clr.
//
// Ports
//   clk       clock, rising edge
//   clr       asynchronous active-high reset (clears state and memory)
//   req       access request, sampled only while idle
//   we        1 = store, 0 = load
//   size      00 byte, 01 halfword, 10 word, 11 illegal
//   uns       load extension: 1 = zero-extend, 0 = sign-extend
//   addr      byte address (ADDR_W+2 bits)
//   wdata     store data, right-justified for byte/halfword
//   rdata     registered load result, held between completions
//   ready     one-cycle completion pulse
//   busy      high whenever an access is in flight
//   misalign  one-cycle fault pulse, coincident with ready
//   dbg_addr  word address for the side-effect-free debug read port
//   dbg_data  combinational contents of word dbg_addr
// -----------------------------------------------------------------------------
module dmem_ctrl #(
    parameter int ADDR_W = 6,
    parameter int WAIT   = 1
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              req,
    input  logic              we,
    input  logic [1:0]        size,
    input  logic              uns,
    input  logic [ADDR_W+1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    output logic              ready,
    output logic              busy,
    output logic              misalign,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [31:0]       dbg_data
);

    localparam int         DEPTH    = 2 ** ADDR_W;
    localparam logic [3:0] CNT_INIT = (WAIT > 0) ? 4'(WAIT - 1) : 4'd0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              we_q, we_d;
    logic [1:0]        size_q, size_d;
    logic              uns_q, uns_d;
    logic [ADDR_W+1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              mis_q, mis_d;
    logic [31:0]       rdata_q, rdata_d;
    logic [31:0]       mem_q [DEPTH];
    logic [31:0]       mem_d [DEPTH];

    // Operands of the access being completed. Accesses that finish straight
    // out of IDLE (no wait states, or misaligned) have not been latched yet,
    // so the live inputs are used in IDLE and the latched copy elsewhere.
    logic              a_we, a_uns;
    logic [1:0]        a_size;
    logic [ADDR_W+1:0] a_addr;
    logic [31:0]       a_wdata;

    assign a_we    = (state_q == S_IDLE) ? we    : we_q;
    assign a_size  = (state_q == S_IDLE) ? size  : size_q;
    assign a_uns   = (state_q == S_IDLE) ? uns   : uns_q;
    assign a_addr  = (state_q == S_IDLE) ? addr  : addr_q;
    assign a_wdata = (state_q == S_IDLE) ? wdata : wdata_q;

    logic a_mis;
    assign a_mis = (a_size == 2'b11)
                 | ((a_size == 2'b01) & a_addr[0])
                 | ((a_size == 2'b10) & (a_addr[1:0] != 2'b00));

    logic [ADDR_W-1:0] a_idx;
    logic [31:0]       a_word;
    logic [31:0]       a_shifted;
    assign a_idx     = a_addr[ADDR_W+1:2];
    assign a_word    = mem_q[a_idx];
    // Brings the addressed byte/halfword down to bit 0.
    assign a_shifted = a_word >> {a_addr[1:0], 3'b000};

    // Load result formatting and store lane merging.
    logic [31:0] load_val;
    logic [3:0]  be;
    logic [31:0] lane_data;
    logic [31:0] merged;

    // NOTE: every signal written in an always_comb block gets a default
    // before any branch, so no path leaves it unassigned and no latch is
    // inferred.
    always_comb begin
        load_val  = a_word;
        be        = 4'b1111;
        lane_data = a_wdata;
        case (a_size)
            2'b00: begin
                load_val  = a_uns ? {24'h0, a_shifted[7:0]}
                                  : {{24{a_shifted[7]}}, a_shifted[7:0]};
                be        = 4'b0001 << a_addr[1:0];
                lane_data = {4{a_wdata[7:0]}};
            end
            2'b01: begin
                load_val  = a_uns ? {16'h0, a_shifted[15:0]}
                                  : {{16{a_shifted[15]}}, a_shifted[15:0]};
                be        = a_addr[1] ? 4'b1100 : 4'b0011;
                lane_data = {2{a_wdata[15:0]}};
            end
            default: begin
                load_val  = a_word;
                be        = 4'b1111;
                lane_data = a_wdata;
            end
        endcase
        for (int b = 0; b < 4; b++) begin
            merged[8*b +: 8] = be[b] ? lane_data[8*b +: 8] : a_word[8*b +: 8];
        end
    end

    // Next-state, operand latching and commit.
    logic commit;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        size_d  = size_q;
        uns_d   = uns_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        mis_d   = mis_q;
        rdata_d = rdata_q;
        mem_d   = mem_q;
        commit  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (req) begin
                    we_d    = we;
                    size_d  = size;
                    uns_d   = uns;
                    addr_d  = addr;
                    wdata_d = wdata;
                    mis_d   = a_mis;
                    if (a_mis) begin
                        state_d = S_DONE;
                    end else if (WAIT == 0) begin
                        state_d = S_DONE;
                        commit  = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = CNT_INIT;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_DONE;
                    commit  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                mis_d   = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // The store or load takes effect on the edge that enters DONE.
        if (commit) begin
            if (a_we) begin
                mem_d[a_idx] = merged;
            end else begin
                rdata_d = load_val;
            end
        end
    end

    // NOTE: sequential state is updated with non-blocking assignments so all
    // flops sample their _d values from the same pre-edge snapshot.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            size_q  <= 2'b00;
            uns_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= 32'h0;
            mis_q   <= 1'b0;
            rdata_q <= 32'h0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            mis_q   <= mis_d;
            rdata_q <= rdata_d;
        end
    end

    // NOTE: the array must read as all zeros right after clr, so it is built
    // from resettable flops rather than a RAM macro, which cannot be cleared
    // asynchronously.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 32'h0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    assign rdata    = rdata_q;
    assign ready    = (state_q == S_DONE);
    assign busy     = (state_q != S_IDLE);
    assign misalign = (state_q == S_DONE) & mis_q;
    assign dbg_data = mem_q[dbg_addr];

endmodule

// File: doc/dmem_ctrl.md
DMEM_CTRL -- requirements
Module: dmem_ctrl

Interface
REQ-001 Parameter ADDR_W, default 6, word-address width; depth = 2**ADDR_W 32-bit words.
REQ-002 Parameter WAIT, default 1, extra wait-state cycles per access, legal range 0..15.
REQ-003 clk  in  1  clock; all state updates on rising edge.
REQ-004 clr  in  1  reset, asynchronous, active-high.
REQ-005 req  in  1  access request; sampled only in IDLE.
REQ-006 we  in  1  1 = store, 0 = load.
REQ-007 size  in  2  00 byte, 01 halfword, 10 word, 11 illegal.
REQ-008 uns  in  1  load extension: 1 = zero-extend, 0 = sign-extend.
REQ-009 addr  in  ADDR_W+2  byte address, little-endian.
REQ-010 wdata  in  32  store data, right-justified for byte/half.
REQ-011 rdata  out  32  registered load result, held between completions.
REQ-012 ready  out  1  one-cycle completion pulse.
REQ-013 busy  out  1  high whenever state != IDLE.
REQ-014 misalign  out  1  one-cycle fault pulse, coincident with ready.
REQ-015 dbg_addr  in  ADDR_W  display read word address.
REQ-016 dbg_data  out  32  combinational read of word dbg_addr; no side effects.

Function
REQ-017 FSM states: IDLE, WAIT, DONE; ready = (state==DONE).
REQ-018 IDLE with req=1: latch we, size, uns, addr, wdata; go WAIT with counter=WAIT-1 if WAIT>0, else go DONE directly.
REQ-019 WAIT: counter decrements each cycle; at counter==0 go DONE; req ignored.
REQ-020 DONE: go IDLE next cycle; req ignored; one access per WAIT+2 cycles maximum.
REQ-021 Store commit and rdata update occur on the edge entering DONE; request accepted in cycle T completes (ready high) in cycle T+1+WAIT.
REQ-022 Misaligned: size==11, or size==01 with addr[0]=1, or size==10 with addr[1:0]!=00.
REQ-023 Misaligned request: go DONE directly (no wait states), misalign=1 with ready, no memory write, rdata unchanged.
REQ-024 Byte store: write wdata[7:0] to lane addr[1:0] of word addr[ADDR_W+1:2]; other lanes unchanged.
REQ-025 Half store: write wdata[15:0] to lanes {addr[1],1}:{addr[1],0}; other lanes unchanged.
REQ-026 Word store: write full wdata.
REQ-027 Byte load: lane addr[1:0], extended per uns to 32 bits; half load: half addr[1], extended per uns; word load: full word.
REQ-028 Store completion leaves rdata unchanged.
REQ-029 dbg_data reflects a store from the cycle after its commit edge.
REQ-030 busy, ready, misalign never high in IDLE.

Reset
REQ-031 clr=1: all memory words 0, state IDLE, counter 0, rdata 0, ready 0, misalign 0, busy 0, immediately without clk.
REQ-032 clr during WAIT: access aborted, pending store not committed, no ready pulse issued.
REQ-033 First request is accepted in the first IDLE cycle after clr deasserts.

Verification
REQ-034 WAIT=1: word store addr 0x08 data 0xDEADBEEF at T -> ready at T+2, busy T+1..T+2, dbg_addr=2 gives 0xDEADBEEF from T+3.
REQ-035 After REQ-034: byte load addr 0x0B uns=0 -> rdata 0xFFFFFFDE; uns=1 -> 0x000000DE; half load addr 0x08 uns=0 -> 0xFFFFBEEF.
REQ-036 Byte store 0x55 to addr 0x09 over 0xDEADBEEF -> word 2 reads 0xDEAD55EF; half store 0x1234 to addr 0x0A -> 0x123455EF.
REQ-037 Word load addr 0x06 -> misalign and ready at T+1, rdata unchanged, memory unchanged; size=11 at addr 0 behaves identically.
REQ-038 WAIT=3: store accepted at T, clr pulsed at T+2 -> no ready, word reads 0, next load accepted after release completes 4 cycles after acceptance.
REQ-039 WAIT=0: req held high continuously -> accepts every 2 cycles, ready alternating 0/1, busy alternating 1/0 pattern matching states.
